// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial shifter, each bit held BIT_CYCLES clocks,
// with a one-cycle done pulse after the last bit and a ready/valid load handshake.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST   = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic             w_accept;
    logic             w_bit_end;

    assign load_ready = (r_state == IDLE);
    assign w_accept   = load_valid && load_ready;
    assign w_bit_end  = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_state   <= SHIFT;
                        r_shift   <= data_in;
                        r_cnt     <= RELOAD;
                        r_idx     <= '0;
                        sdo       <= data_in[WIDTH-1];
                        sdo_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!w_bit_end) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_idx == LAST) begin
                        r_state   <= DONE;
                        sdo       <= 1'b0;
                        sdo_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        // next bit comes from the shifter before it moves, keeping sdo registered
                        r_shift <= r_shift << 1;
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= RELOAD;
                        sdo     <= r_shift[WIDTH-2];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    sdo       <= 1'b0;
                    sdo_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of the serializer at BIT_CYCLES=2 and BIT_CYCLES=1.
module tb_bit_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       load_valid = 1'b0;
    logic       load_ready, sdo, sdo_valid, done;
    logic [7:0] data_in1 = '0;
    logic       load_valid1 = 1'b0;
    logic       load_ready1, sdo1, sdo_valid1, done1;
    int         total = 0;
    int         bad = 0;

    always #42 clk = ~clk;

    bit_serializer #(.WIDTH(8), .BIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .sdo(sdo), .sdo_valid(sdo_valid), .done(done)
    );

    bit_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in1), .load_valid(load_valid1),
        .load_ready(load_ready1), .sdo(sdo1), .sdo_valid(sdo_valid1), .done(done1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++;
        if ({sdo, sdo_valid, done, load_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_state: sdo/valid/done/ready=%b want 0001", {sdo, sdo_valid, done, load_ready});
        end
        rst = 1'b0;
        tick;
        total++;
        if (load_ready !== 1'b1 || sdo_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b want 1 0", load_ready, sdo_valid);
        end
        // asynchronous reset in the middle of a frame
        data_in = 8'hA5;
        load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        tick;
        total++;
        if (sdo !== 1'b1 || sdo_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre: sdo=%b valid=%b want 1 1", sdo, sdo_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({sdo, sdo_valid, done, load_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_async: sdo/valid/done/ready=%b want 0001", {sdo, sdo_valid, done, load_ready});
        end
        tick;
        tick;
        tick;
        rst = 1'b0;
        tick;
        total++;
        if ({sdo, sdo_valid, done, load_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_after: sdo/valid/done/ready=%b want 0001", {sdo, sdo_valid, done, load_ready});
        end
    endtask

    task automatic test_single;
        logic [15:0] pat = 16'hCC33;
        data_in = 8'hA5;
        load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (sdo !== pat[15-i] || sdo_valid !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL single_c%0d: sdo=%b valid=%b done=%b want %b 1 0", i, sdo, sdo_valid, done, pat[15-i]);
            end
            tick;
        end
        total++;
        if ({sdo, sdo_valid, done} !== 3'b001) begin
            bad++;
            $display("FAIL single_done: sdo/valid/done=%b want 001", {sdo, sdo_valid, done});
        end
        tick;
        total++;
        if ({done, load_ready} !== 2'b01) begin
            bad++;
            $display("FAIL single_idle: done/ready=%b want 01", {done, load_ready});
        end
    endtask

    task automatic test_busy;
        logic [15:0] pat = 16'h0FF0;
        int dones = 0;
        data_in = 8'h3C;
        load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (sdo !== pat[15-i] || sdo_valid !== 1'b1 || load_ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_c%0d: sdo=%b valid=%b ready=%b want %b 1 0", i, sdo, sdo_valid, load_ready, pat[15-i]);
            end
            data_in = 8'hFF;
            load_valid = (i >= 2 && i < 12);
            tick;
        end
        load_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dones += done;
            tick;
        end
        total++;
        if (dones != 1 || sdo_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_done: pulses=%0d valid=%b want 1 0", dones, sdo_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] pat1 = 16'hC003;
        logic [15:0] pat2 = 16'h3FFC;
        data_in = 8'h81;
        load_valid = 1'b1;
        tick;
        data_in = 8'h7E;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (sdo !== pat1[15-i] || sdo_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_a%0d: sdo=%b valid=%b want %b 1", i, sdo, sdo_valid, pat1[15-i]);
            end
            tick;
        end
        total++;
        if ({sdo_valid, done} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_done1: valid/done=%b want 01", {sdo_valid, done});
        end
        tick;
        total++;
        if ({sdo_valid, done, load_ready} !== 3'b001) begin
            bad++;
            $display("FAIL b2b_gap: valid/done/ready=%b want 001", {sdo_valid, done, load_ready});
        end
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (sdo !== pat2[15-i] || sdo_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_b%0d: sdo=%b valid=%b want %b 1", i, sdo, sdo_valid, pat2[15-i]);
            end
            tick;
        end
        total++;
        if ({sdo_valid, done} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_done2: valid/done=%b want 01", {sdo_valid, done});
        end
        tick;
    endtask

    task automatic test_bit1;
        logic [7:0] pat = 8'h01;
        data_in1 = 8'h01;
        load_valid1 = 1'b1;
        tick;
        load_valid1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sdo1 !== pat[7-i] || sdo_valid1 !== 1'b1) begin
                bad++;
                $display("FAIL bc1_c%0d: sdo=%b valid=%b want %b 1", i, sdo1, sdo_valid1, pat[7-i]);
            end
            tick;
        end
        total++;
        if ({sdo1, sdo_valid1, done1} !== 3'b001) begin
            bad++;
            $display("FAIL bc1_done: sdo/valid/done=%b want 001", {sdo1, sdo_valid1, done1});
        end
        tick;
        total++;
        if ({done1, load_ready1} !== 2'b01) begin
            bad++;
            $display("FAIL bc1_idle: done/ready=%b want 01", {done1, load_ready1});
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] pat1 = 16'hFF00;
        logic [15:0] pat2 = 16'h00FF;
        int dones = 0;
        data_in = 8'hF0;
        load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sdo !== pat1[15-i] || sdo_valid !== 1'b1) begin
                bad++;
                $display("FAIL abort_c%0d: sdo=%b valid=%b want %b 1", i, sdo, sdo_valid, pat1[15-i]);
            end
            tick;
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dones += done;
            tick;
        end
        total++;
        if (dones != 0 || sdo_valid !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_nodone: pulses=%0d valid=%b ready=%b want 0 0 1", dones, sdo_valid, load_ready);
        end
        data_in = 8'h0F;
        load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (sdo !== pat2[15-i] || sdo_valid !== 1'b1) begin
                bad++;
                $display("FAIL reload_c%0d: sdo=%b valid=%b want %b 1", i, sdo, sdo_valid, pat2[15-i]);
            end
            tick;
        end
        total++;
        if ({sdo_valid, done} !== 2'b01) begin
            bad++;
            $display("FAIL reload_done: valid/done=%b want 01", {sdo_valid, done});
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_busy;
        test_back_to_back;
        test_bit1;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
